vga_pixel_pipe: RTL and testbench
=================================

# vga_pixel_pipe

Pixel-fetch pipeline between the VGA timing controller and the video memory read port. It takes the controller's pixel address and sync/blank strobes, fetches packed 32-bit words of four 8-bit RGB332 pixels, and drives the DAC outputs R/G/B with sync/blank delayed to match. A one-word buffer cuts memory reads to one per four pixels. A write snoop keeps processor stores coherent with the buffer.

## Interface
- `ADDR_W`, 18: pixel address width; word address is `ADDR_W-2` bits.
- `clk`  in  1  system clock; only clock.
- `reset`  in  1  asynchronous, active-high.
- `pix_en`  in  1  pixel strobe, one `clk` wide. Consecutive strobes are at least 2 clocks apart.
- `hsync_in`, `vsync_in`, `sync_b_in`, `blank_b_in`  in  1 each  timing controller outputs, sampled on `pix_en`.
- `pxl_addr`  in  ADDR_W  pixel index; `[1:0]` selects the byte, `[ADDR_W-1:2]` is the word.
- `mem_rd`  out  1  one-clock read request.
- `mem_addr`  out  ADDR_W-2  word address for `mem_rd`.
- `mem_rdata`  in  32  read data, valid exactly 1 clock after `mem_rd`.
- `snoop_we`  in  1  video-memory write strobe from the address decoder.
- `snoop_addr`  in  ADDR_W-2  word address of that write.
- `hsync`, `vsync`, `sync_b`, `blank_b`  out  1 each  delayed timing.
- `R`, `G`, `B`  out  8 each  pixel colour.

## Operation
- Buffer state: `buf_data[31:0]`, `buf_tag[ADDR_W-3:0]`, `buf_valid`.
- **S1** (on `pix_en`):
  - Latch timing inputs and `pxl_addr[1:0]`.
  - Miss = `blank_b_in` && (!`buf_valid` || `buf_tag` != `pxl_addr[ADDR_W-1:2]`).
  - On miss, assert `mem_rd` for that clock with `mem_addr` = word index.
  - On hit or blank, no read.
- **Fill**: the clock after `mem_rd`, load `buf_data` <= `mem_rdata`, `buf_tag` <= requested word, `buf_valid` <= 1.
- **S2** (next `pix_en`):
  - Byte p = `buf_data[8*sel +: 8]`; byte 0 is bits [7:0].
  - If S1 blank, RGB = 0.
  - RGB332 expansion: R = {p[7:5],p[7:5],p[7:6]}, G = {p[4:2],p[4:2],p[4:3]}, B = {p[1:0] replicated 4 times}.
- **Output** (next `pix_en`): register S2 colour and S2 timing onto the ports.
- **Blank invalidation**: sampling `blank_b_in`=0 clears `buf_valid`, so every line refetches.
- **Snoop invalidation**:
  - `snoop_we` with `snoop_addr` == `buf_tag` clears `buf_valid`.
  - Snoop hit in the same clock as Fill: data is still loaded, `buf_valid` ends 0. The pending pixel uses the loaded data; the next pixel refetches.
  - Snoop hit in the same clock as an S1 hit: the hit stands for that pixel.
- **Reset mid-line**: the pipeline flushes. The first pixel after reset is always a miss.

## Timing
- Latency is exactly 2 strobes: inputs sampled at strobe k appear on outputs right after strobe k+2. Sync/blank and colour stay aligned.
- Outputs change only on `pix_en` clocks and hold between strobes.
- `mem_rd` is high at most 1 clock per strobe and never on two consecutive clocks.
- Reset values:
  - `hsync`=1, `vsync`=1, `sync_b`=1, `blank_b`=0.
  - R/G/B=0.
  - `mem_rd`=0, `mem_addr`=0.
  - `buf_valid`=0, `buf_data`=0, `buf_tag`=0, pipeline timing regs = reset values above.
- `pix_en` spacing < 2 clocks is illegal. The bench flags it with an assertion; the RTL does not handle it.

## Structure
- `vga_pipe_pkg`: `rgb332_expand` function, `rgb_t` struct, reset constants for sync/blank.
- Sub-module `pixel_word_buffer`: owns the data, tag and valid regs, the miss compare, Fill and snoop invalidation. It exposes `miss`, `word`, `fill`, `snoop`.
- Top holds S1/S2/output registers and the byte select.

## Test plan
- Reset, then 8 visible strobes at addresses 0..7 with the word at address 0 = 0x44332211 and word 1 = 0x88776655 -> exactly 2 `mem_rd` pulses (`mem_addr` 0 then 1). Output bytes read 0x11,0x22,...,0x88, each 2 strobes after input.
- Pixel 0xE0 -> R=0xFF, G=0, B=0. Pixel 0x1C -> G=0xFF. Pixel 0x03 -> B=0xFF. Pixel 0x00 -> all 0.
- `blank_b_in`=0 for 3 strobes -> no `mem_rd`, RGB=0, `blank_b` low 2 strobes late. The next visible pixel refetches even with the same tag.
- `snoop_we` to the buffered word mid-word -> the next pixel in that word issues `mem_rd`. New data appears on output.
- Snoop coinciding with Fill -> the pending pixel shows the loaded data; the next pixel in the same word refetches.
- Assert `reset` between strobes mid-line -> all outputs at reset values immediately. The first post-reset visible pixel misses.

Source files
------------

// File: rtl/vga_pipe_pkg.sv
// rtl/vga_pipe_pkg.sv - shared types, reset constants and RGB332 expansion for the VGA pixel pipe
package vga_pipe_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic sync_b;
        logic blank_b;
    } timing_t;

    // Idle display: syncs inactive (high), picture blanked.
    localparam timing_t TIMING_RST = '{hsync: 1'b1, vsync: 1'b1, sync_b: 1'b1, blank_b: 1'b0};
    localparam rgb_t    RGB_BLACK  = '{r: 8'h00, g: 8'h00, b: 8'h00};

    // Bit replication so full-scale codes map to 0xFF and zero stays zero.
    function automatic rgb_t rgb332_expand(input logic [7:0] p);
        rgb_t c;
        c.r = {p[7:5], p[7:5], p[7:6]};
        c.g = {p[4:2], p[4:2], p[4:3]};
        c.b = {4{p[1:0]}};
        return c;
    endfunction

endpackage

// File: rtl/pixel_word_buffer.sv
// rtl/pixel_word_buffer.sv - one-word pixel buffer with tag compare, fill and write-snoop invalidation
module pixel_word_buffer #(
    parameter int WORD_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic [WORD_W-1:0] req_tag,
    input  logic [31:0]       fill_data,
    input  logic              inval,
    input  logic              snoop,
    input  logic [WORD_W-1:0] snoop_addr,
    output logic              miss,
    output logic [31:0]       word
);

    logic [31:0]       buf_data;
    logic [WORD_W-1:0] buf_tag;
    logic              buf_valid;
    logic              fill;
    logic [WORD_W-1:0] pend_tag;
    logic              pend_poison;
    logic              snoop_hit_buf;
    logic              snoop_hit_pend;

    assign miss           = !buf_valid || (buf_tag != req_tag);
    assign word           = buf_data;
    assign snoop_hit_buf  = snoop && (snoop_addr == buf_tag);
    assign snoop_hit_pend = snoop && (snoop_addr == pend_tag);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_data    <= '0;
            buf_tag     <= '0;
            buf_valid   <= 1'b0;
            fill        <= 1'b0;
            pend_tag    <= '0;
            pend_poison <= 1'b0;
        end else begin
            fill <= req;
            if (req) begin
                pend_tag    <= req_tag;
                // A store landing on the same edge as the read returns stale data.
                pend_poison <= snoop && (snoop_addr == req_tag);
            end
            if (fill) begin
                buf_data  <= fill_data;
                buf_tag   <= pend_tag;
                buf_valid <= !(pend_poison || snoop_hit_pend);
            end else if (inval || snoop_hit_buf) begin
                buf_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/vga_pixel_pipe.sv
// rtl/vga_pixel_pipe.sv - VGA pixel fetch pipeline: buffered word fetch, byte select, RGB332 expansion
// Two-strobe latency: S1 samples timing and requests the word, S2 forms colour, output stage drives the DAC.
module vga_pixel_pipe
    import vga_pipe_pkg::*;
#(
    parameter int ADDR_W = 18
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pix_en,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic              sync_b_in,
    input  logic              blank_b_in,
    input  logic [ADDR_W-1:0] pxl_addr,
    output logic              mem_rd,
    output logic [ADDR_W-3:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    input  logic              snoop_we,
    input  logic [ADDR_W-3:0] snoop_addr,
    output logic              hsync,
    output logic              vsync,
    output logic              sync_b,
    output logic              blank_b,
    output logic [7:0]        R,
    output logic [7:0]        G,
    output logic [7:0]        B
);

    localparam int WORD_W = ADDR_W - 2;

    logic [WORD_W-1:0] word_idx;
    logic              miss;
    logic [31:0]       buf_word;

    timing_t    s1_t, s2_t, out_t;
    logic [1:0] s1_sel;
    rgb_t       s2_rgb, out_rgb;

    assign word_idx = pxl_addr[ADDR_W-1:2];
    assign mem_rd   = pix_en && blank_b_in && miss && !reset;
    assign mem_addr = mem_rd ? word_idx : '0;

    pixel_word_buffer #(
        .WORD_W (WORD_W)
    ) u_buf (
        .clk        (clk),
        .reset      (reset),
        .req        (mem_rd),
        .req_tag    (word_idx),
        .fill_data  (mem_rdata),
        .inval      (pix_en && !blank_b_in),
        .snoop      (snoop_we),
        .snoop_addr (snoop_addr),
        .miss       (miss),
        .word       (buf_word)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_t    <= TIMING_RST;
            s1_sel  <= 2'd0;
            s2_t    <= TIMING_RST;
            s2_rgb  <= RGB_BLACK;
            out_t   <= TIMING_RST;
            out_rgb <= RGB_BLACK;
        end else if (pix_en) begin
            s1_t   <= '{hsync: hsync_in, vsync: vsync_in, sync_b: sync_b_in, blank_b: blank_b_in};
            s1_sel <= pxl_addr[1:0];
            s2_t   <= s1_t;
            // The fill for the S1 pixel has landed by the next strobe.
            s2_rgb <= s1_t.blank_b ? rgb332_expand(buf_word[{s1_sel, 3'b000} +: 8]) : RGB_BLACK;
            out_t   <= s2_t;
            out_rgb <= s2_rgb;
        end
    end

    assign hsync   = out_t.hsync;
    assign vsync   = out_t.vsync;
    assign sync_b  = out_t.sync_b;
    assign blank_b = out_t.blank_b;
    assign R       = out_rgb.r;
    assign G       = out_rgb.g;
    assign B       = out_rgb.b;

endmodule

// File: tb/tb_vga_pixel_pipe.sv
// tb/tb_vga_pixel_pipe.sv - self-checking bench for vga_pixel_pipe with memory and pixel reference model
module tb_vga_pixel_pipe;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pix_en = 1'b0;
    logic        hsync_in = 1'b1, vsync_in = 1'b1, sync_b_in = 1'b1, blank_b_in = 1'b0;
    logic [17:0] pxl_addr = '0;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [31:0] mem_rdata = '0;
    logic        snoop_we = 1'b0;
    logic [15:0] snoop_addr = '0;
    logic [31:0] snoop_data = '0;
    logic        hsync, vsync, sync_b, blank_b;
    logic [7:0]  R, G, B;

    logic [27:0] outv;
    assign outv = {hsync, vsync, sync_b, blank_b, R, G, B};

    localparam logic [27:0] RST_VEC = {4'b1110, 24'h0};

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] mem [0:255];
    logic [27:0] exp_q [$];
    logic [15:0] rd_addrs [$];
    int          rd_count = 0;
    logic        prev_rd = 1'b0;
    int          idle_clks = 100;

    always #5 clk = ~clk;

    vga_pixel_pipe #(.ADDR_W(18)) dut (
        .clk        (clk),
        .reset      (reset),
        .pix_en     (pix_en),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .sync_b_in  (sync_b_in),
        .blank_b_in (blank_b_in),
        .pxl_addr   (pxl_addr),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .snoop_we   (snoop_we),
        .snoop_addr (snoop_addr),
        .hsync      (hsync),
        .vsync      (vsync),
        .sync_b     (sync_b),
        .blank_b    (blank_b),
        .R          (R),
        .G          (G),
        .B          (B)
    );

    // Video memory: registered read, processor store on snoop_we.
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem[mem_addr[7:0]];
        if (snoop_we) mem[snoop_addr[7:0]] <= snoop_data;
    end

    always @(posedge clk) begin
        if (mem_rd) begin
            rd_count++;
            rd_addrs.push_back(mem_addr);
            n_chk++;
            assert (prev_rd === 1'b0) else begin
                n_fail++;
                $error("FAIL rd_b2b: mem_rd observed high on consecutive clocks, required isolated pulses");
            end
        end
        prev_rd = mem_rd;
        if (pix_en) begin
            n_chk++;
            assert (idle_clks >= 1) else begin
                n_fail++;
                $error("FAIL pix_spacing: observed %0d idle clocks, required >= 1", idle_clks);
            end
            idle_clks = 0;
        end else if (idle_clks < 100) begin
            idle_clks++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] exp_rgb(input logic [7:0] p);
        int r3, g3, b2, r, g, b;
        r3 = int'(p) / 32;
        g3 = (int'(p) / 4) % 8;
        b2 = int'(p) % 4;
        r  = r3 * 32 + r3 * 4 + r3 / 2;
        g  = g3 * 32 + g3 * 4 + g3 / 2;
        b  = b2 * 85;
        return {8'(r), 8'(g), 8'(b)};
    endfunction

    // smode: 0 no store, 1 store on strobe clock, 2 on fill clock, 3 on last idle clock.
    task automatic strobe(input int a, input logic vis, input logic [2:0] syn, input int smode, input int gap);
        logic [31:0] w;
        logic [7:0]  p;
        logic [27:0] e;
        w = mem[a / 4];
        p = 8'(w >> (8 * (a % 4)));
        e = {syn, vis, (vis ? exp_rgb(p) : 24'h0)};
        exp_q.push_back(e);
        pxl_addr   = 18'(a);
        blank_b_in = vis;
        {hsync_in, vsync_in, sync_b_in} = syn;
        pix_en     = 1'b1;
        snoop_we   = (smode == 1);
        @(posedge clk); #1;
        pix_en   = 1'b0;
        snoop_we = 1'b0;
        e = exp_q.pop_front();
        chk("out", 32'(outv), 32'(e));
        for (int i = 0; i < gap; i++) begin
            snoop_we = (smode == 2 && i == 0) || (smode == 3 && i == gap - 1);
            @(posedge clk); #1;
            snoop_we = 1'b0;
        end
        chk("hold", 32'(outv), 32'(e));
    endtask

    task automatic restart_model();
        exp_q.delete();
        exp_q.push_back(RST_VEC);
        exp_q.push_back(RST_VEC);
    endtask

    initial begin
        int base;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[0] = 32'h44332211;
        mem[1] = 32'h88776655;
        mem[2] = 32'h00031CE0;
        mem[3] = 32'hA5A5A5A5;
        mem[4] = 32'h12345678;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out", 32'(outv), 32'(RST_VEC));
        chk("rst_mem_rd", 32'(mem_rd), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        reset = 1'b0;
        restart_model();

        // Sequential visible pixels: one read per word.
        rd_addrs.delete();
        for (int i = 0; i < 8; i++) strobe(i, 1'b1, 3'b111, 0, 1);
        chk("seq_rd_count", 32'(rd_count), 32'd2);
        chk("seq_rd_addr0", 32'(rd_addrs[0]), 32'd0);
        chk("seq_rd_addr1", 32'(rd_addrs[1]), 32'd1);

        // Colour extremes from word 2.
        base = rd_count;
        strobe(8, 1'b1, 3'b111, 0, 1);
        strobe(9, 1'b1, 3'b111, 0, 1);
        strobe(10, 1'b1, 3'b111, 0, 1);
        chk("red_full", 32'({R, G, B}), 32'h00FF0000);
        strobe(11, 1'b1, 3'b111, 0, 1);
        chk("green_full", 32'({R, G, B}), 32'h0000FF00);
        chk("word2_rd", 32'(rd_count), 32'(base + 1));

        // Blanking: no reads, black, then refetch of the same word.
        base = rd_count;
        strobe(11, 1'b0, 3'b010, 0, 1);
        chk("blue_full", 32'({R, G, B}), 32'h000000FF);
        strobe(11, 1'b0, 3'b001, 0, 1);
        chk("black", 32'({R, G, B}), 32'h0);
        strobe(11, 1'b0, 3'b011, 0, 1);
        chk("blank_no_rd", 32'(rd_count), 32'(base));
        strobe(11, 1'b1, 3'b111, 0, 1);
        chk("blank_refetch", 32'(rd_count), 32'(base + 1));

        // Store to the buffered word between pixels forces a refetch.
        base = rd_count;
        snoop_addr = 16'd3;
        snoop_data = 32'h0000FF00;
        strobe(12, 1'b1, 3'b111, 3, 2);
        strobe(13, 1'b1, 3'b111, 0, 1);
        chk("snoop_refetch", 32'(rd_count), 32'(base + 2));

        // Store coinciding with the fill: loaded data used once, then refetch.
        base = rd_count;
        snoop_addr = 16'd4;
        snoop_data = 32'hDEADBEEF;
        strobe(16, 1'b1, 3'b111, 2, 1);
        strobe(17, 1'b1, 3'b111, 0, 1);
        chk("fill_snoop_refetch", 32'(rd_count), 32'(base + 2));

        // Asynchronous reset mid-line.
        strobe(18, 1'b1, 3'b111, 0, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("midline_rst_out", 32'(outv), 32'(RST_VEC));
        chk("midline_rst_rd", 32'(mem_rd), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        restart_model();
        base = rd_count;
        strobe(19, 1'b1, 3'b111, 0, 1);
        chk("post_rst_miss", 32'(rd_count), 32'(base + 1));

        // Random traffic with stores anywhere in the strobe period.
        for (int n = 0; n < 300; n++) begin
            snoop_addr = 16'($urandom_range(0, 15));
            snoop_data = $urandom;
            strobe(int'($urandom_range(0, 63)), ($urandom_range(0, 7) != 0), 3'($urandom),
                   int'($urandom_range(0, 3)), int'($urandom_range(1, 3)));
        end
        strobe(0, 1'b0, 3'b111, 0, 1);
        strobe(0, 1'b0, 3'b111, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
